// File: rtl/pixel_ctrl_pkg.sv
// Shared definitions for the pixel readout controller: state encoding,
// default phase lengths and the phase-timer load helper.
package pixel_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ERASE,
    ST_EXPOSE,
    ST_CONVERT,
    ST_TURN,
    ST_READ1,
    ST_HOLD1,
    ST_READ2,
    ST_HOLD2
  } state_e;

  localparam int DEF_ERASE_CYCLES   = 5;
  localparam int DEF_EXPOSE_CYCLES  = 255;
  localparam int DEF_CONVERT_CYCLES = 256;
  localparam int READ_CYCLES        = 2;
  localparam int TIMER_W            = 9;

  // The timer counts down to zero inclusive, so a phase of N cycles loads N-1.
  function automatic logic [TIMER_W-1:0] cycles_to_load(input int cycles);
    return TIMER_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/pixel_readout_ctrl_phase_timer.sv
// Loadable down-counter shared by every timed phase; done is high while
// the count sits at zero, i.e. on the last cycle of the phase.
module phase_timer
  import pixel_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  output logic               done
);

  logic [TIMER_W-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - TIMER_W'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/pixel_readout_ctrl.sv
// Pixel sensor frame sequencer: erase, expose, ramp conversion on the shared
// column buses, then two row reads delivered over a valid/ready output.
//
// Output handshake: a transfer happens on a rising edge where out_valid and
// out_ready are both 1; out_valid and the data stay stable until then, and
// out_ready is ignored while out_valid is 0.
module pixel_readout_ctrl
  import pixel_ctrl_pkg::*;
#(
  parameter int C_ERASE_CYCLES   = DEF_ERASE_CYCLES,
  parameter int C_EXPOSE_CYCLES  = DEF_EXPOSE_CYCLES,
  parameter int C_CONVERT_CYCLES = DEF_CONVERT_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       erase,
  output logic       expose,
  output logic       convert,
  output logic       read1,
  output logic       read2,
  inout  wire  [7:0] pixData1,
  inout  wire  [7:0] pixData2,
  output logic [7:0] out_data1,
  output logic [7:0] out_data2,
  output logic       out_row,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic       frame_done,
  output state_e     state_dbg
);

  state_e             state;
  state_e             next_state;
  logic               t_load;
  logic [TIMER_W-1:0] t_val;
  logic               t_done;
  logic               drive_en;
  logic [7:0]         bus_q;
  logic               handshake;

  phase_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (t_load),
    .load_val (t_val),
    .done     (t_done)
  );

  assign handshake = out_valid && out_ready;

  always_comb begin
    next_state = state;
    t_load     = 1'b0;
    t_val      = '0;
    case (state)
      ST_IDLE: if (start) begin
        next_state = ST_ERASE;
        t_load     = 1'b1;
        t_val      = cycles_to_load(C_ERASE_CYCLES);
      end
      ST_ERASE: if (t_done) begin
        next_state = ST_EXPOSE;
        t_load     = 1'b1;
        t_val      = cycles_to_load(C_EXPOSE_CYCLES);
      end
      ST_EXPOSE: if (t_done) begin
        next_state = ST_CONVERT;
        t_load     = 1'b1;
        t_val      = cycles_to_load(C_CONVERT_CYCLES);
      end
      ST_CONVERT: if (t_done) next_state = ST_TURN;
      ST_TURN: begin
        next_state = ST_READ1;
        t_load     = 1'b1;
        t_val      = cycles_to_load(READ_CYCLES);
      end
      ST_READ1: if (t_done) next_state = ST_HOLD1;
      ST_HOLD1: if (handshake) begin
        next_state = ST_READ2;
        t_load     = 1'b1;
        t_val      = cycles_to_load(READ_CYCLES);
      end
      ST_READ2: if (t_done) next_state = ST_HOLD2;
      ST_HOLD2: if (handshake) next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // Every output is a flop decoded from next_state, so each one is high
  // exactly while the FSM sits in the matching state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      erase      <= 1'b0;
      expose     <= 1'b0;
      convert    <= 1'b0;
      drive_en   <= 1'b0;
      read1      <= 1'b0;
      read2      <= 1'b0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      bus_q      <= 8'h00;
      out_data1  <= 8'h00;
      out_data2  <= 8'h00;
      out_row    <= 1'b0;
    end else begin
      state      <= next_state;
      erase      <= (next_state == ST_ERASE);
      expose     <= (next_state == ST_EXPOSE);
      convert    <= (next_state == ST_CONVERT);
      drive_en   <= (next_state == ST_CONVERT);
      read1      <= (next_state == ST_READ1);
      read2      <= (next_state == ST_READ2);
      out_valid  <= (next_state == ST_HOLD1) || (next_state == ST_HOLD2);
      busy       <= (next_state != ST_IDLE);
      frame_done <= (state == ST_HOLD2) && handshake;
      // The ramp stops incrementing as CONVERT ends, so 255 is never followed by 0.
      if (next_state == ST_CONVERT) begin
        bus_q <= (state == ST_CONVERT) ? bus_q + 8'd1 : 8'd0;
      end
      if (state == ST_READ1 && t_done) begin
        out_data1 <= pixData1;
        out_data2 <= pixData2;
        out_row   <= 1'b0;
      end
      if (state == ST_READ2 && t_done) begin
        out_data1 <= pixData1;
        out_data2 <= pixData2;
        out_row   <= 1'b1;
      end
    end
  end

  assign pixData1  = drive_en ? bus_q : 8'hzz;
  assign pixData2  = drive_en ? bus_q : 8'hzz;
  assign state_dbg = state;

endmodule
